// File: rtl/tour_cmd_pkg.sv
// Shared types and constants for the Knight command sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tour_cmd_pkg;

  // Sequencer states; the encoding is fixed so waveforms stay readable.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_SENT = 3'd2,
    WAIT_RESP = 3'd3,
    ERROR     = 3'd4
  } state_t;

  // Knight command encodings: a 4-bit opcode in [15:12] and a 12-bit argument.
  localparam logic [15:0] CAL_GYRO   = 16'h2000;
  localparam logic [3:0]  MOVE_OP    = 4'h4;
  localparam logic [3:0]  FANFARE_OP = 4'h5;
  localparam logic [3:0]  TOUR_OP    = 4'h6;

  // Positive acknowledge byte returned by the Knight.
  localparam logic [7:0]  ACK_VAL_DEF = 8'hA5;

  // Builds a command word from an opcode and its argument field.
  function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/tour_cmd_sequencer_cmd_fifo.sv
// Command queue: DEPTH x W synchronous FIFO with flush and occupancy count.
// Latency: a push is visible on o_dat/o_count one cycle later; o_dat is the head, read without delay.
// Backpressure: push while full is dropped unless a pop happens the same cycle; flush drops that cycle's push.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  typedef logic [AW:0] cnt_t;
  localparam cnt_t LP_DEPTH = cnt_t'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  cnt_t          r_count;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_count == LP_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dat   = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a push alongside it is taken even when full.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  // Pointer and occupancy bookkeeping; flush returns everything to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Queues Knight commands and issues them one at a time over send_cmd/cmd_sent/resp_rdy with retry.
// Latency: first send_cmd two cycles after the push into an empty, idle queue; one command in flight.
// Backpressure: full flags a saturated queue and further pushes are dropped; ERROR stalls issue until clr_err.
module tour_cmd_sequencer
  import tour_cmd_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd4_000_000,
  parameter int          MAX_RETRY    = 2,
  parameter logic [7:0]  ACK_VAL      = ACK_VAL_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              cmd_in,
  input  logic                     push,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic [7:0]               cmds_done,
  output logic                     err,
  output logic [15:0]              err_cmd
);

  localparam logic [7:0] LP_MAX_RETRY = 8'(MAX_RETRY);

  state_t      r_state;
  logic [15:0] r_cmd;
  logic [15:0] r_err_cmd;
  logic [7:0]  r_retry;
  logic [7:0]  r_done;
  logic [31:0] r_timer;

  logic [15:0] w_head;
  logic        w_empty;
  logic        w_pop;
  logic        w_timeout;
  logic        w_retry_ok;

  // Head is consumed only from IDLE; flush wins over a pop in the same cycle.
  assign w_pop      = (r_state == IDLE) && !w_empty && !flush;
  assign w_timeout  = (r_timer == (TIMEOUT_CLKS - 32'd1));
  assign w_retry_ok = (r_retry < LP_MAX_RETRY);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_dat   (cmd_in),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_dat   (w_head),
    .o_full  (full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // Outputs decode straight from registers so reset drops send_cmd without a glitch.
  assign send_cmd  = (r_state == SEND);
  assign busy      = (r_state != IDLE);
  assign err       = (r_state == ERROR);
  assign cmd       = r_cmd;
  assign cmds_done = r_done;
  assign err_cmd   = r_err_cmd;

  // Issue/acknowledge FSM with retry counter, response timer and completion count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cmd     <= '0;
      r_err_cmd <= '0;
      r_retry   <= '0;
      r_done    <= '0;
      r_timer   <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_retry <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_cmd   <= w_head;
            r_retry <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          r_state <= WAIT_SENT;
        end
        WAIT_SENT: begin
          if (cmd_sent) begin
            r_timer <= '0;
            r_state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response in the timeout cycle beats the timeout.
          if (resp_rdy && (resp == ACK_VAL)) begin
            r_done  <= r_done + 8'd1;
            r_state <= IDLE;
          end else if (resp_rdy || w_timeout) begin
            if (w_retry_ok) begin
              r_retry <= r_retry + 8'd1;
              r_state <= SEND;
            end else begin
              r_err_cmd <= r_cmd;
              r_state   <= ERROR;
            end
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 32'd1;
          end
        end
        ERROR: begin
          if (clr_err) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
